inst_fetcher: RTL and testbench

Instruction fetch stage of the out-of-order core: owns the architectural fetch PC, issues one word-fetch at a time to the memory controller, predicts the next PC (static JAL, predictor-assisted conditional branch), and buffers fetched words in a small FIFO. It sits directly upstream of the decode/issue stage, which consumes `{inst, inst_pc, inst_pred}` through a valid/ack handshake. A flush from the flow controller redirects fetch and discards all buffered and in-flight instructions.

---
 rtl/inst_fetcher_if.sv | 26 ++
 rtl/inst_fetcher.sv | 109 ++++++++++
 tb/tb_inst_fetcher.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_if.sv
// inst_fetcher_if: memory fetch port, flush/redirect and decode-side handshake of the fetch stage.
interface inst_fetcher_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        clr;
    logic [31:0] clr_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pred;
    logic        inst_ack;

    modport master (
        output mem_req, mem_addr, pred_pc, inst_valid, inst, inst_pc, inst_pred,
        input  mem_valid, mem_data, pred_taken, clr, clr_pc, inst_ack
    );

    modport slave (
        input  mem_req, mem_addr, pred_pc, inst_valid, inst, inst_pc, inst_pred,
        output mem_valid, mem_data, pred_taken, clr, clr_pc, inst_ack
    );
endinterface

// File: rtl/inst_fetcher.sv
// inst_fetcher: owns the fetch PC, issues one word fetch at a time, predicts the next PC
// and queues {inst, pc, predicted next pc} for decode.
module inst_fetcher #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    inst_fetcher_if.master bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n, addr, addr_n, next_pc, j_imm, b_imm, d;
    logic          req, req_n, push, pop;
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, count_n;
    logic [31:0]   q_inst [QUEUE_DEPTH];
    logic [31:0]   q_pc   [QUEUE_DEPTH];
    logic [31:0]   q_pred [QUEUE_DEPTH];

    assign d     = bus.mem_data;
    assign j_imm = {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
    assign b_imm = {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
    assign next_pc = (d[6:0] == OP_JAL) ? addr + j_imm :
                     (d[6:0] == OP_BR && bus.pred_taken) ? addr + b_imm : addr + 32'd4;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = addr;
        req_n   = req;
        push    = 1'b0;
        pop     = bus.inst_valid && bus.inst_ack && !bus.clr;
        if (bus.clr) begin
            // an outstanding request must still see its response before fetch restarts
            pc_n    = bus.clr_pc;
            req_n   = state != FETCH && !bus.mem_valid;
            state_n = (state != FETCH && !bus.mem_valid) ? DROP : FETCH;
        end else begin
            case (state)
                FETCH: if (count < FULL) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = WAIT;
                end
                WAIT: if (bus.mem_valid) begin
                    push    = 1'b1;
                    pc_n    = next_pc;
                    req_n   = 1'b0;
                    state_n = FETCH;
                end
                default: if (bus.mem_valid) begin
                    req_n   = 1'b0;
                    state_n = FETCH;
                end
            endcase
        end
        count_n = bus.clr ? '0 : count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else if (rdy) state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_PC;
            addr  <= RESET_PC;
            req   <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
                q_pred[i] <= '0;
            end
        end else if (rdy) begin
            pc    <= pc_n;
            addr  <= addr_n;
            req   <= req_n;
            head  <= bus.clr ? '0 : head + AW'(pop);
            tail  <= bus.clr ? '0 : tail + AW'(push);
            count <= count_n;
            if (push) begin
                q_inst[tail] <= d;
                q_pc[tail]   <= addr;
                q_pred[tail] <= next_pc;
            end
        end
    end

    assign bus.mem_req    = req;
    assign bus.mem_addr   = addr;
    assign bus.pred_pc    = addr;
    assign bus.inst_valid = count != '0;
    assign bus.inst       = q_inst[head];
    assign bus.inst_pc    = q_pc[head];
    assign bus.inst_pred  = q_pred[head];
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: scoreboard bench; the memory model pushes expected queue entries as it responds,
// each test task pops and compares as the decoder side accepts instructions.
module tb_inst_fetcher;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    inst_fetcher_if bus();

    inst_fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    bit          drop_next = 1'b0;
    bit          taken_cfg = 1'b1;
    bit          rose = 1'b0;
    bit          prev_req = 1'b0;
    logic [31:0] model_pc = 32'h0;
    logic [95:0] sb[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a == 32'h10 ? 32'h0080006F : a == 32'h20 ? 32'hFE000EE3 : 32'h00000013;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] w, input logic [31:0] a, input bit tk);
        logic [31:0] j = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        logic [31:0] b = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        if (w[6:0] == 7'b1101111) return a + j;
        if (w[6:0] == 7'b1100011 && tk) return a + b;
        return a + 32'd4;
    endfunction

    // memory controller: answers the outstanding request lat cycles after it first appears
    initial begin
        logic [31:0] w;
        bus.mem_valid = 1'b0;
        bus.mem_data = '0;
        bus.pred_taken = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_valid = 1'b0;
            if (!rst || !bus.mem_req) wait_cnt = 0;
            else if (rdy) begin
                wait_cnt++;
                if (wait_cnt > lat) begin
                    w = word_at(model_pc);
                    bus.mem_valid = 1'b1;
                    bus.mem_data = w;
                    bus.pred_taken = taken_cfg;
                    wait_cnt = 0;
                    if (drop_next) drop_next = 1'b0;
                    else begin
                        sb.push_back({w, model_pc, model_next(w, model_pc, taken_cfg)});
                        model_pc = model_next(w, model_pc, taken_cfg);
                    end
                end
            end
        end
    end

    task automatic step(output bit took, output logic [95:0] got);
        took = bus.inst_valid && bus.inst_ack && rdy && rst && !bus.clr;
        got = {bus.inst, bus.inst_pc, bus.inst_pred};
        @(negedge clk);
        cyc++;
        rose = bus.mem_req && !prev_req;
        prev_req = bus.mem_req;
    endtask

    task automatic test_reset;
        bit took;
        logic [95:0] got;
        bus.clr = 1'b0;
        bus.clr_pc = '0;
        bus.inst_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.pred_pc, bus.inst_valid} !== 66'h0) begin
            failures++;
            $display("FAIL reset_ctrl got req=%b addr=%h pred_pc=%h valid=%b exp all zero", bus.mem_req, bus.mem_addr, bus.pred_pc, bus.inst_valid);
        end
        checks++;
        if ({bus.inst, bus.inst_pc, bus.inst_pred} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus.inst, bus.inst_pc, bus.inst_pred});
        end
        rst = 1'b1;
        step(took, got);
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_sequential;
        bit took;
        logic [95:0] got, exp;
        int k = 0, r4 = 0, r8 = 0;
        bus.inst_ack = 1'b1;
        for (int n = 0; n < 40 && k < 3; n++) begin
            step(took, got);
            if (rose && bus.mem_addr == 32'h4) r4 = cyc;
            if (rose && bus.mem_addr == 32'h8) r8 = cyc;
            if (took) begin
                exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL seq_sb got=%h exp=%h", got, exp); end
                checks++;
                if (got !== {32'h13, 32'(4 * k), 32'(4 * k + 4)}) begin
                    failures++;
                    $display("FAIL seq_entry%0d got=%h exp=%h", k, got, {32'h13, 32'(4 * k), 32'(4 * k + 4)});
                end
                k++;
            end
        end
        checks++;
        if (k != 3) begin failures++; $display("FAIL seq_count got=%0d exp=3", k); end
        checks++;
        if (r8 - r4 != 3) begin failures++; $display("FAIL req_period got=%0d exp=3", r8 - r4); end
    endtask

    task automatic test_jal;
        bit took, seen = 1'b0, done = 1'b0;
        logic [95:0] got, exp;
        for (int n = 0; n < 60 && !done; n++) begin
            step(took, got);
            if (took) begin
                exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL jal_sb got=%h exp=%h", got, exp); end
                if (got[63:32] == 32'h10) begin
                    seen = 1'b1;
                    checks++;
                    if (got[31:0] !== 32'h18) begin failures++; $display("FAIL jal_pred got=%h exp=00000018", got[31:0]); end
                end
            end
            if (seen && rose) begin
                done = 1'b1;
                checks++;
                if (bus.mem_addr !== 32'h18) begin failures++; $display("FAIL jal_next_addr got=%h exp=00000018", bus.mem_addr); end
            end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL jal_timeout got=0 exp=1"); end
    endtask

    task automatic test_branch;
        bit took;
        logic [95:0] got, exp;
        int hits = 0;
        for (int n = 0; n < 80 && hits < 2; n++) begin
            step(took, got);
            if (took) begin
                exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL br_sb got=%h exp=%h", got, exp); end
                if (got[63:32] == 32'h20) begin
                    checks++;
                    if (got[31:0] !== (hits == 0 ? 32'h1C : 32'h24)) begin
                        failures++;
                        $display("FAIL br_pred%0d got=%h exp=%h", hits, got[31:0], hits == 0 ? 32'h1C : 32'h24);
                    end
                    hits++;
                    taken_cfg = 1'b0;
                end
            end
        end
        checks++;
        if (hits != 2) begin failures++; $display("FAIL br_timeout got=%0d exp=2", hits); end
    endtask

    task automatic test_full;
        bit took;
        logic [95:0] got, exp;
        int low = 0, rises = 0;
        bus.inst_ack = 1'b0;
        for (int n = 0; n < 25; n++) begin
            step(took, got);
            if (n >= 17 && !bus.mem_req) low++;
        end
        checks++;
        if (sb.size() != 4 || !bus.inst_valid) begin
            failures++;
            $display("FAIL full_count got=%0d valid=%b exp=4 valid=1", sb.size(), bus.inst_valid);
        end
        checks++;
        if (low != 8) begin failures++; $display("FAIL full_req_low got=%0d exp=8", low); end
        bus.inst_ack = 1'b1;
        step(took, got);
        bus.inst_ack = 1'b0;
        exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
        checks++;
        if (!took || got !== exp) begin failures++; $display("FAIL full_pop got=%h took=%b exp=%h", got, took, exp); end
        for (int n = 0; n < 15; n++) begin
            step(took, got);
            if (rose) rises++;
        end
        checks++;
        if (rises != 1 || sb.size() != 4 || bus.mem_req) begin
            failures++;
            $display("FAIL full_refill got rises=%0d count=%0d req=%b exp 1/4/0", rises, sb.size(), bus.mem_req);
        end
    endtask

    task automatic test_clr;
        bit took, done = 1'b0;
        logic [95:0] got, exp;
        lat = 6;
        bus.inst_ack = 1'b1;
        repeat (2) begin
            step(took, got);
            if (took) begin
                exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL clr_pre_sb got=%h exp=%h", got, exp); end
            end
        end
        bus.inst_ack = 1'b0;
        checks++;
        if ({bus.mem_req, bus.inst_valid} !== 2'b11 || sb.size() != 2) begin
            failures++;
            $display("FAIL clr_pre got req=%b valid=%b count=%0d exp 1/1/2", bus.mem_req, bus.inst_valid, sb.size());
        end
        bus.clr = 1'b1;
        bus.clr_pc = 32'h100;
        model_pc = 32'h100;
        drop_next = 1'b1;
        sb.delete();
        step(took, got);
        bus.clr = 1'b0;
        checks++;
        if ({bus.inst_valid, bus.mem_req} !== 2'b01) begin
            failures++;
            $display("FAIL clr_flush got valid=%b req=%b exp valid=0 req=1", bus.inst_valid, bus.mem_req);
        end
        for (int n = 0; n < 40 && !done; n++) begin
            step(took, got);
            if (rose) begin
                done = 1'b1;
                checks++;
                if (bus.mem_addr !== 32'h100) begin failures++; $display("FAIL clr_addr got=%h exp=00000100", bus.mem_addr); end
            end
        end
        bus.inst_ack = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step(took, got);
            if (took) begin
                done = 1'b1;
                exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
                checks++;
                if (got !== exp || got[63:32] !== 32'h100) begin failures++; $display("FAIL clr_first got=%h exp=%h", got, exp); end
            end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL clr_timeout got=0 exp=1"); end
    endtask

    task automatic test_rdy_hold;
        bit took, done = 1'b0;
        logic [95:0] got, exp, hd;
        logic [31:0] pend;
        lat = 10;
        bus.inst_ack = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            step(took, got);
            done = bus.inst_valid && bus.mem_req;
        end
        repeat (2) step(took, got);
        pend = model_pc;
        hd = sb.size() != 0 ? sb[0] : {96{1'bx}};
        rdy = 1'b0;
        bus.inst_ack = 1'b1;
        repeat (5) begin
            step(took, got);
            checks++;
            if ({bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_pred} !== {1'b1, pend, 1'b1, hd}) begin
                failures++;
                $display("FAIL rdy_hold got req=%b addr=%h valid=%b head=%h exp req=1 addr=%h valid=1 head=%h",
                         bus.mem_req, bus.mem_addr, bus.inst_valid, {bus.inst, bus.inst_pc, bus.inst_pred}, pend, hd);
            end
        end
        rdy = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            step(took, got);
            if (took) begin
                exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL rdy_sb got=%h exp=%h", got, exp); end
                done = got[63:32] == pend;
            end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL rdy_resume got=0 exp=1"); end
    endtask

    task automatic test_async_reset;
        bit took, done = 1'b0;
        logic [95:0] got, exp;
        bus.inst_ack = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            step(took, got);
            done = bus.inst_valid && bus.mem_req;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.pred_pc, bus.inst_valid} !== 66'h0) begin
            failures++;
            $display("FAIL async_ctrl got req=%b addr=%h valid=%b exp all zero", bus.mem_req, bus.mem_addr, bus.inst_valid);
        end
        checks++;
        if ({bus.inst, bus.inst_pc, bus.inst_pred} !== 96'h0) begin
            failures++;
            $display("FAIL async_data got=%h exp=0", {bus.inst, bus.inst_pc, bus.inst_pred});
        end
        sb.delete();
        model_pc = 32'h0;
        lat = 1;
        step(took, got);
        rst = 1'b1;
        bus.inst_ack = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            step(took, got);
            if (took) begin
                done = 1'b1;
                exp = sb.size() != 0 ? sb.pop_front() : {96{1'bx}};
                checks++;
                if (got !== exp || got !== {32'h13, 32'h0, 32'h4}) begin
                    failures++;
                    $display("FAIL async_restart got=%h exp=%h", got, {32'h13, 32'h0, 32'h4});
                end
            end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL async_timeout got=0 exp=1"); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jal();
        test_branch();
        test_full();
        test_clr();
        test_rdy_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
